fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and decode front end of the 16-bit CPU. Fetches instruction words from instruction memory over a req/ack handshake, assembles two-word long-immediate instructions, and presents one decoded instruction per transfer to the operand-select stage: 5-bit opcode to the opcode mux, 2-bit word select to the 4-way operand mux, and immediate/PC words as mux inputs. Handles branch redirects from execute.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset
- LIMM_OPCODE, 5'h1F, opcode marking a two-word instruction (second word is the full immediate)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_imem_req  out  1  fetch request
- o_imem_addr  out  16  fetch address
- i_imem_ack  in  1  data valid this cycle; completes request
- i_imem_data  in  16  instruction word
- i_redirect  in  1  branch taken; flush and refetch
- i_redirect_pc  in  16  redirect target
- o_valid  out  1  decoded instruction available
- i_ready  in  1  downstream accepts when o_valid & i_ready
- o_opcode  out  5  instr bits [0:4]
- o_src_sel  out  2  instr bits [5:6], operand mux select
- o_rd  out  3  instr bits [7:9]
- o_imm  out  16  sign-extended bits [10:15], or extension word for LIMM
- o_pc  out  16  address of first word of instruction

## Operation
- States: FETCH (request outstanding), EXT (extension-word request outstanding), HOLD (o_valid high, awaiting i_ready), DROP (discarding an in-flight word after redirect).
- Reset: state FETCH-pending; pc = RESET_PC; o_imem_req=0, o_valid=0, all data outputs 0. First cycle after reset release: o_imem_req=1, o_imem_addr=RESET_PC.
- FETCH: req held high, addr stable until ack. On ack: if opcode==LIMM_OPCODE latch word, pc+=1, go EXT; else latch decoded fields, pc+=1, go HOLD.
- EXT: req high at pc; on ack o_imm=data, pc+=1, go HOLD. o_pc = address of first word.
- HOLD: outputs stable. On i_ready: if no redirect, issue next fetch same cycle as acceptance takes effect (req high next cycle), go FETCH.
- Redirect (any state, highest priority): o_valid cleared next edge, pc=i_redirect_pc. If a request is outstanding and no ack this cycle, go DROP: req stays high (request never withdrawn), returning word discarded, then fetch target. Ack coincident with redirect: word discarded, fetch target next cycle.
- Redirect in HOLD with i_ready high: transfer still counts as accepted; flush applies after.
- pc arithmetic modulo 2^16; 16'hFFFF wraps to 16'h0000, including mid-LIMM.
- Sign extension: o_imm = {10{bit10}, bits[10:15]}.

## Timing
- Ack in cycle N (single-word): o_valid=1 from cycle N+1.
- LIMM: o_valid one cycle after second ack.
- Back-to-back with zero-wait memory and i_ready held: one instruction per 2 cycles (fetch, hold).
- o_imem_addr/o_imem_req are registered; no combinational path from i_imem_ack or i_ready to outputs.
- Reset asserted mid-transaction: all outputs return to reset values immediately; a late ack after reset release while req=0 is ignored.

## Structure
- Shared package: instruction field offsets/widths, LIMM_OPCODE, RESET_PC default, state encoding.
- One sub-module natural: imm_sext (6-to-16 sign extender), combinational, reusable by execute.

## Test plan
- Reset release, memory returns 16'h1234 with ack one cycle later -> o_valid next cycle, o_opcode=5'h02, o_src_sel=2'b01, o_rd=3'b000, o_imm=16'hFFF4, o_pc=16'h0000.
- LIMM: words 16'hF800 then 16'hBEEF -> o_opcode=5'h1F, o_imm=16'hBEEF, o_pc=0, next fetch addr 16'h0002.
- i_ready low 5 cycles in HOLD -> all outputs stable, o_imem_req=0; on i_ready next fetch addr pc+1.
- Redirect to 16'h0100 while request outstanding, ack 2 cycles later -> req never drops, returned word discarded, next request addr 16'h0100, o_valid stays 0 until its ack.
- RESET_PC=16'hFFFF, LIMM at FFFF -> extension fetched from 16'h0000, o_pc=16'hFFFF.
- Reset asserted while in EXT -> o_valid=0, o_imem_req=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch/decode front end.
package fetch_unit_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned RD_W     = 3;
  localparam int unsigned IMM6_W   = 6;

  // Field positions: instruction bit 0 is the word MSB, so [0:4] maps to [15:11]
  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned SEL_LSB  = 9;
  localparam int unsigned RD_LSB   = 6;
  localparam int unsigned IMM6_LSB = 0;

  localparam logic [OPC_W-1:0] LIMM_OPCODE      = 5'h1F;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXT   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  // Decoded instruction presented to operand select
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [SEL_W-1:0] src_sel;
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
  } instr_t;

endpackage

// File: rtl/fetch_unit_imm_sext.sv
// 6-to-16 bit sign extender for short immediates; purely combinational.
module fetch_unit_imm_sext
  import fetch_unit_pkg::*;
(
  input  logic [IMM6_W-1:0] i_imm6,
  output logic [XLEN-1:0]   o_imm_c
);

  // Replicate the field's top bit into the upper bits
  assign o_imm_c = {{(XLEN-IMM6_W){i_imm6[IMM6_W-1]}}, i_imm6};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and decode front end: fetches over req/ack, assembles
// two-word long-immediate instructions and handles branch redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [XLEN-1:0]   i_imem_data,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [SEL_W-1:0]  o_src_sel,
  output logic [RD_W-1:0]   o_rd,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_pc
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  instr_t            instr_q, instr_d;

  logic              ack_c;
  logic [OPC_W-1:0]  word_opc_c;
  logic              is_limm_c;
  logic [XLEN-1:0]   sext_imm_c;

  // An ack only completes a request that is actually being presented
  assign ack_c      = i_imem_ack & req_q;
  assign word_opc_c = i_imem_data[OPC_LSB +: OPC_W];
  assign is_limm_c  = (word_opc_c == LIMM_OPCODE);

  fetch_unit_imm_sext u_imm_sext (
    .i_imm6  (i_imem_data[IMM6_LSB +: IMM6_W]),
    .o_imm_c (sext_imm_c)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (i_redirect) begin
          state_d = (req_q && !i_imem_ack) ? ST_DROP : ST_FETCH;
        end else if (ack_c) begin
          state_d = is_limm_c ? ST_EXT : ST_HOLD;
        end
      end
      ST_EXT: begin
        if (i_redirect) begin
          state_d = ack_c ? ST_FETCH : ST_DROP;
        end else if (ack_c) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_redirect || i_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (ack_c) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_FETCH: begin
        if (ack_c && !i_redirect) begin
          instr_d.opcode  = word_opc_c;
          instr_d.src_sel = i_imem_data[SEL_LSB +: SEL_W];
          instr_d.rd      = i_imem_data[RD_LSB +: RD_W];
          instr_d.imm     = sext_imm_c;
          instr_d.pc      = pc_q;
          pc_d            = pc_q + XLEN'(1);
          valid_d         = !is_limm_c;
        end
      end
      ST_EXT: begin
        if (ack_c && !i_redirect) begin
          instr_d.imm = i_imem_data;
          pc_d        = pc_q + XLEN'(1);
          valid_d     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (i_redirect) begin
      valid_d = 1'b0;
      pc_d    = i_redirect_pc;
    end
    // Request is up in every state except while holding a decoded instruction
    req_d  = (state_d != ST_HOLD);
    // A discarded request keeps its address until the memory answers
    addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
    end
  end

  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;
  assign o_valid     = valid_q;
  assign o_opcode    = instr_q.opcode;
  assign o_src_sel   = instr_q.src_sel;
  assign o_rd        = instr_q.rd;
  assign o_imm       = instr_q.imm;
  assign o_pc        = instr_q.pc;

endmodule
